demux81_seq: RTL
================

Name: demux81_seq

Overview:
- Registered 1:8 demultiplexer with a built-in scan sequencer. It is the distribution end of the 8:1 select path in the traffic controller.
- A single WIDTH-bit code (default 5 bits, the lane/phase code width) is steered into one of eight holding registers Y1..Y8. The target is chosen either by external select lines S1..S3 or by an internal auto-increment pointer.
- Per-slot valid flags, a frame-complete pulse and a sticky overwrite flag let the controller know when all eight lanes have been loaded.

Parameters:
WIDTH, 5, bit width of the data code and of each output register Y1..Y8

Ports:
CLK  input  1  system clock; all state changes on rising edge
RSTN  input  1  asynchronous active-low reset
D  input  WIDTH  data code to be distributed
S1  input  1  select bit 0 (LSB) in manual mode
S2  input  1  select bit 1 in manual mode
S3  input  1  select bit 2 (MSB) in manual mode
LD  input  1  write strobe; one write per cycle it is high
AUTO  input  1  1 = target from internal pointer, 0 = target from {S3,S2,S1}
CLR  input  1  synchronous frame clear
Y1..Y8  output  WIDTH each  holding registers; Yn corresponds to index n-1
VLD  output  8  VLD[n-1] = 1 when Yn has been written since last reset/CLR
PTR  output  3  current auto pointer value
DONE  output  1  one-cycle pulse: frame complete
OVF  output  1  sticky: a slot was written while already valid

Behaviour:
- Reset, RSTN low, asynchronous: Y1..Y8 = 0, VLD = 8'h00, PTR = 0, DONE = 0, OVF = 0. Reset takes effect immediately and holds while low. Release is synchronous in effect: the first update happens on the first CLK edge with RSTN high.
- Target index: sel = AUTO ? PTR : {S3,S2,S1}. Index 0 maps to Y1 and index 7 maps to Y8, matching the X1..X8 ordering of the selector.
- Write, when LD=1 and CLR=0 at a rising edge:
  - Y[sel] <= D and VLD[sel] <= 1.
  - All other Y and VLD bits hold.
  - Latency: new value is visible on Yn one cycle after the LD edge.
- Pointer:
  - Advances only on an auto write (LD=1, AUTO=1, CLR=0): PTR <= PTR+1 modulo 8, so 7 wraps to 0.
  - Manual writes never move PTR.
  - Toggling AUTO mid-frame leaves PTR unchanged.
- Overwrite: if LD=1, CLR=0 and VLD[sel] is already 1, the write still occurs and OVF <= 1. OVF stays set until CLR or reset.
- DONE is registered. It is 1 for exactly the cycle after the edge at which VLD goes from not-all-ones to 8'hFF. It is 0 otherwise, including on later overwrites while VLD stays 8'hFF.
- CLR=1 at an edge:
  - VLD <= 0, PTR <= 0, OVF <= 0, DONE <= 0.
  - Y1..Y8 retain their values, so the outputs keep driving the last codes.
  - CLR has priority over LD: a simultaneous write is dropped entirely (no Y update, no PTR advance).
- Select lines and AUTO are sampled only when LD=1; they are don't-care otherwise.
- No combinational path from inputs to outputs; all outputs come straight from registers.

Test Plan:
- Reset: RSTN=0 mid-operation with Y3=5'h1A -> immediately Y1..Y8=0, VLD=00, PTR=0, OVF=0, DONE=0 without waiting for a CLK edge.
- Manual steer: AUTO=0, {S3,S2,S1}=3'b101, D=5'h13, LD pulse -> next cycle Y6=5'h13, VLD=8'h20, PTR=0, all other Y unchanged.
- Auto frame: AUTO=1, eight consecutive LD cycles with D=1..8 -> Y1..Y8=1..8, PTR wraps back to 0, VLD=FF, DONE high for exactly one cycle after the 8th write, OVF=0.
- Overwrite: after the auto frame, one more auto LD with D=5'h1F -> Y1=5'h1F, PTR=1, OVF=1 sticky, DONE stays 0.
- CLR priority: CLR=1 and LD=1 in the same cycle with AUTO=1, D=5'h0C -> VLD=00, PTR=0, OVF=0, no Y changes.
- Mixed mode: auto writes to Y1,Y2 (PTR=2), then manual write to index 2 (Y3), then auto write -> auto write lands in Y3, overwriting it, OVF=1, PTR=3.

Source files
------------

// File: rtl/demux81_seq_if.sv
// Signal bundle between the traffic controller's select path and the 1:8 distribution registers.
// The controller (master) drives the code, select and strobe lines; the demux (slave) returns holding registers and frame status.
interface demux81_seq_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] D;
  logic             S1;
  logic             S2;
  logic             S3;
  logic             LD;
  logic             AUTO;
  logic             CLR;
  logic [WIDTH-1:0] Y1;
  logic [WIDTH-1:0] Y2;
  logic [WIDTH-1:0] Y3;
  logic [WIDTH-1:0] Y4;
  logic [WIDTH-1:0] Y5;
  logic [WIDTH-1:0] Y6;
  logic [WIDTH-1:0] Y7;
  logic [WIDTH-1:0] Y8;
  logic [7:0]       VLD;
  logic [2:0]       PTR;
  logic             DONE;
  logic             OVF;

  // Strobe protocol: each cycle LD is high at a rising edge is one write and needs no acknowledge.
  // CLR at the same edge wins, and the write is dropped.
  modport master (
    output D, S1, S2, S3, LD, AUTO, CLR,
    input  Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, VLD, PTR, DONE, OVF
  );

  modport slave (
    input  D, S1, S2, S3, LD, AUTO, CLR,
    output Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, VLD, PTR, DONE, OVF
  );
endinterface

// File: rtl/demux81_seq.sv
// Registered 1:8 demultiplexer with an auto-increment scan pointer.
// It steers one code into eight holding registers and reports slot validity, frame completion and overwrites.
module demux81_seq #(
  parameter int WIDTH = 5
) (
  input  logic         CLK,
  input  logic         RSTN,
  demux81_seq_if.slave bus
);

  logic [WIDTH-1:0] r_y [8];
  logic [7:0]       r_vld;
  logic [2:0]       r_ptr;
  logic             r_done;
  logic             r_ovf;

  logic [2:0]       w_sel;
  logic             w_wr;
  logic [7:0]       w_vld_nxt;

  always_comb begin
    w_sel     = bus.AUTO ? r_ptr : {bus.S3, bus.S2, bus.S1};
    w_wr      = bus.LD & ~bus.CLR;
    w_vld_nxt = r_vld;
    if (w_wr) begin
      w_vld_nxt = r_vld | (8'(1) << w_sel);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 8; i++) begin
        r_y[i] <= '0;
      end
      r_vld  <= 8'h00;
      r_ptr  <= 3'd0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.CLR) begin
      // Frame clear leaves the Y registers alone so the lanes keep their last codes.
      r_vld  <= 8'h00;
      r_ptr  <= 3'd0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      // DONE fires only on the not-full to full transition, never on later overwrites.
      r_done <= (r_vld != 8'hFF) && (w_vld_nxt == 8'hFF);
      if (w_wr) begin
        r_y[w_sel] <= bus.D;
        r_vld      <= w_vld_nxt;
        if (r_vld[w_sel]) begin
          r_ovf <= 1'b1;
        end
        if (bus.AUTO) begin
          r_ptr <= r_ptr + 3'd1;
        end
      end
    end
  end

  assign bus.Y1   = r_y[0];
  assign bus.Y2   = r_y[1];
  assign bus.Y3   = r_y[2];
  assign bus.Y4   = r_y[3];
  assign bus.Y5   = r_y[4];
  assign bus.Y6   = r_y[5];
  assign bus.Y7   = r_y[6];
  assign bus.Y8   = r_y[7];
  assign bus.VLD  = r_vld;
  assign bus.PTR  = r_ptr;
  assign bus.DONE = r_done;
  assign bus.OVF  = r_ovf;

endmodule
